// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-beat SDRAM controller.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              p0_valid;
  logic              p0_ready;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_valid;
  logic              p1_ready;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic              ctrl_valid;
  logic              ctrl_ready;
  logic              ctrl_we;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [DATA_W-1:0] ctrl_wdata;
  logic              ctrl_rvalid;
  logic [DATA_W-1:0] ctrl_rdata;
  logic              rsp_orphan;

  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_wdata,
    output p0_ready, p0_rvalid, p0_rdata,
    input  p1_valid, p1_we, p1_addr, p1_wdata,
    output p1_ready, p1_rvalid, p1_rdata,
    output ctrl_valid, ctrl_we, ctrl_addr, ctrl_wdata,
    input  ctrl_ready, ctrl_rvalid, ctrl_rdata,
    output rsp_orphan
  );

  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata,
    input  p0_ready, p0_rvalid, p0_rdata,
    output p1_valid, p1_we, p1_addr, p1_wdata,
    input  p1_ready, p1_rvalid, p1_rdata,
    input  ctrl_valid, ctrl_we, ctrl_addr, ctrl_wdata,
    output ctrl_ready, ctrl_rvalid, ctrl_rdata,
    input  rsp_orphan
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of a single-beat SDRAM controller with in-order read tag FIFO.
// Define SDRAM_ARB_RR_EN for round-robin arbitration instead of P0 priority with P1 starvation bound.
module sdram_port_arbiter #(
  parameter int ADDR_W        = 24,
  parameter int DATA_W        = 16,
  parameter int RD_FIFO_DEPTH = 8,
  parameter int MAX_WAIT      = 15
) (
  input logic               SYS_CLK,
  input logic               RESET_N,
  sdram_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_reg, state_next;
  logic             grant_reg, grant_next;
  logic             tag_mem [RD_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             orphan_reg;

  logic [1:0] valid, we_vec, eligible;
  logic       fifo_full, fifo_empty, head;
  logic       win, have_win, active, accept, push, pop;

  assign valid      = {bus.p1_valid, bus.p0_valid};
  assign we_vec     = {bus.p1_we, bus.p0_we};
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(RD_FIFO_DEPTH));

  // A read may only compete while there is room for its tag (pre-pop count).
  for (genvar gi = 0; gi < 2; gi++) begin : g_elig
    assign eligible[gi] = valid[gi] && (we_vec[gi] || !fifo_full);
  end

`ifdef SDRAM_ARB_RR_EN
  logic last_reg;
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N)    last_reg <= 1'b1;
    else if (accept) last_reg <= win;
  end
`else
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              wait_max;
  assign wait_max = (wait_cnt_reg == WAIT_W'(MAX_WAIT));
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N)                          wait_cnt_reg <= '0;
    else if (!bus.p1_valid || bus.p1_ready) wait_cnt_reg <= '0;
    else if (!wait_max)                     wait_cnt_reg <= wait_cnt_reg + 1'b1;
  end
`endif

  always_comb begin
    state_next = IDLE;
    grant_next = grant_reg;
    win        = 1'b0;
    have_win   = 1'b0;
    if (state_reg == HOLD) begin
      win      = grant_reg;
      have_win = valid[grant_reg];
    end else begin
`ifdef SDRAM_ARB_RR_EN
      if (&eligible) begin
        win      = ~last_reg;
        have_win = 1'b1;
      end else if (eligible[0]) begin
        have_win = 1'b1;
      end else if (eligible[1]) begin
        win      = 1'b1;
        have_win = 1'b1;
      end
`else
      if (eligible[1] && wait_max) begin
        win      = 1'b1;
        have_win = 1'b1;
      end else if (eligible[0]) begin
        have_win = 1'b1;
      end else if (eligible[1]) begin
        win      = 1'b1;
        have_win = 1'b1;
      end
`endif
    end
    if (have_win && !bus.ctrl_ready) begin
      state_next = HOLD;
      grant_next = win;
    end
  end

  // Outputs are forced low while reset is asserted, even with requests pending.
  assign active = have_win && RESET_N;
  assign accept = active && bus.ctrl_ready;
  assign push   = accept && !bus.ctrl_we;
  assign head   = tag_mem[rd_ptr_reg];
  assign pop    = bus.ctrl_rvalid && !fifo_empty && RESET_N;

  assign bus.ctrl_valid = active;
  assign bus.ctrl_we    = active && (win ? bus.p1_we : bus.p0_we);
  assign bus.ctrl_addr  = active ? (win ? bus.p1_addr : bus.p0_addr) : '0;
  assign bus.ctrl_wdata = active ? (win ? bus.p1_wdata : bus.p0_wdata) : '0;
  assign bus.p0_ready   = accept && !win;
  assign bus.p1_ready   = accept && win;
  assign bus.p0_rvalid  = pop && !head;
  assign bus.p1_rvalid  = pop && head;
  assign bus.p0_rdata   = (pop && !head) ? bus.ctrl_rdata : '0;
  assign bus.p1_rdata   = (pop && head) ? bus.ctrl_rdata : '0;
  assign bus.rsp_orphan = orphan_reg;

  always_ff @(posedge SYS_CLK) begin
    if (push) tag_mem[wr_ptr_reg] <= win;
  end

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg  <= IDLE;
      grant_reg  <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      orphan_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
      if (bus.ctrl_rvalid && fifo_empty) orphan_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the arbitration and tag rules.
module tb_sdram_port_arbiter;
  localparam int ADDR_W   = 24;
  localparam int DATA_W   = 16;
  localparam int DEPTH    = 8;
  localparam int MAX_WAIT = 15;

  typedef struct packed {
    logic              cv;
    logic              port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              acc;
    logic              orphan;
  } cyc_t;

  typedef struct packed {
    logic              port;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic clk;
  logic rst_n;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_FIFO_DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .SYS_CLK(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  cyc_t              cyc_q[$];
  rsp_t              rsp_q[$];
  logic [DATA_W-1:0] ctrl_pend[$];
  bit                mtags[$];
  int                mwait;
  bit                mhold, mgrant, morphan;

  bit                rv[2];
  bit                rwe[2];
  logic [ADDR_W-1:0] raddr[2];
  logic [DATA_W-1:0] rwd[2];
  bit                c_ready, c_rvalid;
  logic [DATA_W-1:0] c_rdata;
  bit                auto_rsp;
  int                rsp_pct;

  task automatic drive_bus();
    bus.p0_valid    = rv[0];
    bus.p0_we       = rwe[0];
    bus.p0_addr     = raddr[0];
    bus.p0_wdata    = rwd[0];
    bus.p1_valid    = rv[1];
    bus.p1_we       = rwe[1];
    bus.p1_addr     = raddr[1];
    bus.p1_wdata    = rwd[1];
    bus.ctrl_ready  = c_ready;
    bus.ctrl_rvalid = c_rvalid;
    bus.ctrl_rdata  = c_rdata;
  endtask

  task automatic model_reset();
    mtags.delete();
    ctrl_pend.delete();
    mwait   = 0;
    mhold   = 0;
    mgrant  = 0;
    morphan = 0;
    rv[0]   = 0;
    rv[1]   = 0;
  endtask

  task automatic set_req(input int p, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    rv[p]    = 1;
    rwe[p]   = we;
    raddr[p] = a;
    rwd[p]   = d;
  endtask

  // One clock: drive inputs, predict this cycle from the model, advance the model.
  task automatic step();
    bit full, e0, e1, vld, win, acc, p1v;
    cyc_t c;
    if (auto_rsp) begin
      c_rvalid = (ctrl_pend.size() > 0) && ($urandom_range(0, 99) < rsp_pct);
      if (c_rvalid) c_rdata = ctrl_pend.pop_front();
    end
    drive_bus();
    full = (mtags.size() == DEPTH);
    e0   = rv[0] && (rwe[0] || !full);
    e1   = rv[1] && (rwe[1] || !full);
    vld  = 0;
    win  = 0;
    if (mhold) begin
      vld = rv[mgrant];
      win = mgrant;
    end else if (e1 && mwait == MAX_WAIT) begin
      vld = 1; win = 1;
    end else if (e0) begin
      vld = 1; win = 0;
    end else if (e1) begin
      vld = 1; win = 1;
    end
    acc      = vld && c_ready;
    c.cv     = vld;
    c.port   = win;
    c.we     = rwe[win];
    c.addr   = raddr[win];
    c.wdata  = rwd[win];
    c.acc    = acc;
    c.orphan = morphan;
    cyc_q.push_back(c);
    if (c_rvalid) begin
      if (mtags.size() > 0) begin
        rsp_q.push_back({mtags[0], c_rdata});
        void'(mtags.pop_front());
      end else begin
        morphan = 1;
      end
    end
    if (acc && !rwe[win]) begin
      mtags.push_back(win);
      ctrl_pend.push_back(DATA_W'($urandom));
    end
    p1v = rv[1];
    if (acc) rv[win] = 0;
    if (!p1v || (acc && win)) mwait = 0;
    else if (mwait < MAX_WAIT) mwait++;
    mhold = vld && !c_ready;
    if (mhold) mgrant = win;
    c_rvalid = 0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    auto_rsp = 1;
    rsp_pct  = 100;
    c_ready  = 1;
    n        = 0;
    while ((ctrl_pend.size() > 0 || rv[0] || rv[1]) && n < 100) begin
      step();
      n++;
    end
    compared++;
    if (n >= 100) begin
      mismatched++;
      $display("FAIL drain_timeout: still pending=%0d after %0d cycles, want 0", ctrl_pend.size(), n);
    end
    auto_rsp = 0;
  endtask

  // Monitor: compares each cycle's command view and every returned read.
  initial begin
    cyc_t c;
    rsp_t r;
    bit ok, dut_rv;
    forever begin
      @(negedge clk);
      #1;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        compared++;
        ok = (bus.ctrl_valid == c.cv) && (bus.rsp_orphan == c.orphan);
        if (c.cv)
          ok = ok && bus.ctrl_addr == c.addr && bus.ctrl_we == c.we && bus.ctrl_wdata == c.wdata
                  && bus.p0_ready == (c.acc && !c.port) && bus.p1_ready == (c.acc && c.port);
        else
          ok = ok && !bus.p0_ready && !bus.p1_ready;
        if (!ok) begin
          mismatched++;
          $display("FAIL cmd t=%0t: got v=%b a=%h we=%b d=%h rdy=%b%b orph=%b; want v=%b port=%0d a=%h we=%b d=%h acc=%b orph=%b",
                   $time, bus.ctrl_valid, bus.ctrl_addr, bus.ctrl_we, bus.ctrl_wdata, bus.p1_ready,
                   bus.p0_ready, bus.rsp_orphan, c.cv, c.port, c.addr, c.we, c.wdata, c.acc, c.orphan);
        end
      end
      dut_rv = bus.p0_rvalid || bus.p1_rvalid;
      if (dut_rv || rsp_q.size() > 0) begin
        compared++;
        if (bus.p0_rvalid && bus.p1_rvalid) begin
          mismatched++;
          $display("FAIL rsp t=%0t: got both rvalid, want one", $time);
          rsp_q.delete();
        end else if (rsp_q.size() == 0) begin
          mismatched++;
          $display("FAIL rsp t=%0t: got rvalid p%0d data=%h, want none", $time, bus.p1_rvalid,
                   bus.p1_rvalid ? bus.p1_rdata : bus.p0_rdata);
        end else begin
          r = rsp_q.pop_front();
          if (!dut_rv || bus.p1_rvalid != r.port
              || (r.port ? bus.p1_rdata : bus.p0_rdata) != r.data) begin
            mismatched++;
            $display("FAIL rsp t=%0t: got rv=%b%b d0=%h d1=%h, want p%0d data=%h", $time,
                     bus.p1_rvalid, bus.p0_rvalid, bus.p0_rdata, bus.p1_rdata, r.port, r.data);
          end
        end
      end
    end
  end

  initial begin
    logic [78:0] outs;
    auto_rsp = 0;
    rsp_pct  = 0;
    model_reset();
    rst_n    = 0;
    set_req(0, 0, 24'h000100, 16'h0);
    set_req(1, 0, 24'h000200, 16'h0);
    c_ready  = 1;
    c_rvalid = 1;
    c_rdata  = 16'hBEEF;
    drive_bus();

    // Reset held with both ports requesting and stray controller data.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      outs = {bus.ctrl_valid, bus.ctrl_we, bus.ctrl_addr, bus.ctrl_wdata, bus.p0_ready,
              bus.p1_ready, bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata, bus.rsp_orphan};
      compared++;
      if (outs != '0) begin
        mismatched++;
        $display("FAIL reset_outputs cycle %0d: got %h, want 0", i, outs);
      end
    end
    @(negedge clk);
    rst_n    = 1;
    c_rvalid = 0;

    // Back-to-back reads on both ports: P0 takes 15 grants, then P1 is forced.
    auto_rsp = 1;
    rsp_pct  = 100;
    for (int i = 0; i < 40; i++) begin
      if (!rv[0]) set_req(0, 0, ADDR_W'(24'h000100 + i), 16'h0);
      if (!rv[1]) set_req(1, 0, ADDR_W'(24'h000200 + i), 16'h0);
      step();
    end
    rv[0] = 0;
    rv[1] = 0;
    drain();

    // P1 granted while the controller stalls; a late P0 request must not steal it.
    c_ready = 0;
    set_req(1, 1, 24'h00ABCD, 16'h1234);
    step();
    set_req(0, 0, 24'h000555, 16'h0);
    for (int i = 0; i < 4; i++) step();
    c_ready = 1;
    step();
    step();
    drain();

    // Fill the tag FIFO with P0 reads; the 9th read stalls while P1's write gets through.
    c_ready = 1;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 0, ADDR_W'(i), 16'h0);
      step();
    end
    set_req(0, 0, 24'h000900, 16'h0);
    set_req(1, 1, 24'h000010, 16'hA5A5);
    for (int i = 0; i < 3; i++) step();
    drain();

    // Interleaved reads return to their issuing ports in order.
    set_req(0, 0, 24'h000010, 16'h0);
    step();
    set_req(1, 0, 24'h000020, 16'h0);
    step();
    set_req(0, 0, 24'h000030, 16'h0);
    step();
    ctrl_pend.delete();
    c_rvalid = 1; c_rdata = 16'h1111; step();
    c_rvalid = 1; c_rdata = 16'h2222; step();
    c_rvalid = 1; c_rdata = 16'h3333; step();

    // Controller data with nothing outstanding is dropped and flagged stickily.
    c_rvalid = 1; c_rdata = 16'hDEAD; step();
    step();
    step();

    // Randomized traffic with alternating slow and fast read return.
    auto_rsp = 1;
    for (int n = 0; n < 800; n++) begin
      rsp_pct = ((n / 100) % 2 == 1) ? 60 : 15;
      for (int p = 0; p < 2; p++)
        if (!rv[p] && $urandom_range(0, 2) != 0)
          set_req(p, bit'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
      c_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset with reads outstanding: flushed tags, late data becomes an orphan.
    rv[0] = 0;
    rv[1] = 0;
    c_ready = 1;
    rsp_pct = 0;
    for (int i = 0; i < 3; i++) begin
      if (!rv[0]) set_req(0, 0, ADDR_W'(24'h000700 + i), 16'h0);
      step();
    end
    rv[0]    = 0;
    auto_rsp = 0;
    rst_n    = 0;
    model_reset();
    drive_bus();
    repeat (3) @(negedge clk);
    rst_n    = 1;
    c_rvalid = 1;
    c_rdata  = 16'h7777;
    step();
    step();
    step();

    @(negedge clk);
    #2;
    compared++;
    if (cyc_q.size() != 0 || rsp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: got cyc=%0d rsp=%0d pending, want 0/0", cyc_q.size(), rsp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
